seq_detect_sched: RTL and testbench

Multi-channel, time-shared serial pattern detector with a round-robin scheduler. Up to NCH serial bit streams compete for a single detection engine. The engine keeps per-channel history contexts and checks each granted bit against a programmable pattern. Overlapping matches are detected. The block sits between the serial front-end channels and the event/interrupt logic, and reports each match with its channel number plus a saturating match count per channel.

---
 rtl/seq_detect_sched.sv | 191 +++++++++++++++++++
 tb/tb_seq_detect_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_sched
// Purpose  : Time-shared serial pattern detector. NCH bit streams share one
//            detection engine through a round-robin arbiter. Each channel
//            keeps its own history and fill context. Overlapping matches are
//            reported with the channel number, and each channel has a
//            saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_sched #(
  parameter int               NCH       = 4,
  parameter int               PAT_W     = 5,
  parameter logic [PAT_W-1:0] PAT_RESET = 5'b10110,
  parameter int               CNT_W     = 8,
  parameter int               CH_W      = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  output logic             cfg_err,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_bit,
  output logic [NCH-1:0]   req_ready,
  output logic             match_valid,
  output logic [CH_W-1:0]  match_ch,
  input  logic             cnt_clr,
  input  logic [CH_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  output logic             busy
);

  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // A channel becomes able to match once PAT_W-1 real bits precede the new one
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CH_W:0]     NCH_EXT  = (CH_W+1)'(NCH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PAT_W-1:0]  r_pattern;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [PAT_W-2:0]  r_hist [NCH];
  logic [FILL_W-1:0] r_fill [NCH];
  logic [CNT_W-1:0]  r_cnt  [NCH];

  logic              w_load_pat;
  logic              w_grant_en;
  logic              w_flush;
  logic              w_xfer;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W:0]     w_scan;
  logic [CH_W-1:0]   w_rr_nxt;
  logic [PAT_W-1:0]  w_window;
  logic              w_hit;

  // Next-state decode; grants only while RUN and enable stays high
  always_comb begin
    w_state_nxt = r_state;
    w_load_pat  = 1'b0;
    w_grant_en  = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_we) begin
          w_load_pat = 1'b1;
        end else if (enable) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (enable) begin
          w_grant_en = 1'b1;
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Round-robin search: first valid channel at or above r_rr_ptr, wrapping
  always_comb begin
    w_xfer    = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = 0; i < NCH; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (w_scan >= NCH_EXT) begin
        w_scan = w_scan - NCH_EXT;
      end
      if (!w_xfer && w_grant_en && req_valid[w_scan[CH_W-1:0]]) begin
        w_xfer    = 1'b1;
        w_gnt_idx = w_scan[CH_W-1:0];
      end
    end
  end

  // One-hot ready toward the winning channel
  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_rr_nxt = (w_gnt_idx == CH_W'(NCH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
  assign w_window = {r_hist[w_gnt_idx], req_bit[w_gnt_idx]};
  assign w_hit    = w_xfer && (r_fill[w_gnt_idx] >= FILL_ARM) && (w_window == r_pattern);
  assign busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign cnt_data = r_cnt[cnt_sel];

  // Control state, pattern, arbitration pointer and match reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pattern   <= PAT_RESET;
      r_rr_ptr    <= '0;
      cfg_err     <= 1'b0;
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      cfg_err     <= (r_state == S_RUN) && cfg_we;
      match_valid <= w_hit;
      if (w_load_pat) begin
        r_pattern <= cfg_pattern;
      end
      if (w_xfer) begin
        r_rr_ptr <= w_rr_nxt;
      end
      if (w_hit) begin
        match_ch <= w_gnt_idx;
      end
    end
  end

  // Per-channel history and fill; FLUSH forgets all received bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_hist[k] <= '0;
        r_fill[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_flush) begin
          r_hist[k] <= '0;
          r_fill[k] <= '0;
        end else if (w_xfer && (w_gnt_idx == CH_W'(k))) begin
          r_hist[k] <= w_window[PAT_W-2:0];
          if (r_fill[k] != FILL_MAX) begin
            r_fill[k] <= r_fill[k] + FILL_W'(1);
          end
        end
      end
    end
  end

  // Saturating match counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_clr) begin
          r_cnt[k] <= '0;
        end else if (w_hit && (w_gnt_idx == CH_W'(k)) && (r_cnt[k] != CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_sched
// Purpose  : Self-checking bench for seq_detect_sched. Every cycle is scored
//            against a bit-history reference model, with table vectors and
//            hand-built sequences layered on top of the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_sched;

  localparam int               NCH       = 4;
  localparam int               PAT_W     = 5;
  localparam int               CNT_W     = 2;
  localparam int               CH_W      = 2;
  localparam logic [PAT_W-1:0] PAT_RESET = 5'b10110;
  localparam int               CNT_MAX   = (1 << CNT_W) - 1;
  localparam int               M_IDLE    = 0;
  localparam int               M_RUN     = 1;
  localparam int               M_FLUSH   = 2;

  logic             clk         = 1'b0;
  logic             rst         = 1'b0;
  logic             enable      = 1'b0;
  logic             cfg_we      = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_err;
  logic [NCH-1:0]   req_valid   = '0;
  logic [NCH-1:0]   req_bit     = '0;
  logic [NCH-1:0]   req_ready;
  logic             match_valid;
  logic [CH_W-1:0]  match_ch;
  logic             cnt_clr     = 1'b0;
  logic [CH_W-1:0]  cnt_sel     = '0;
  logic [CNT_W-1:0] cnt_data;
  logic             busy;

  seq_detect_sched #(
    .NCH(NCH), .PAT_W(PAT_W), .PAT_RESET(PAT_RESET), .CNT_W(CNT_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_bit(req_bit), .req_ready(req_ready),
    .match_valid(match_valid), .match_ch(match_ch),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_data(cnt_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode, pointer, last bits per channel, bits seen, counts
  int m_mode, m_rr, m_pat, m_mv, m_ch, m_err;
  int m_hist [NCH];
  int m_n    [NCH];
  int m_cnt  [NCH];
  logic [NCH-1:0] smp_ready;

  typedef struct {
    logic           en;
    logic [NCH-1:0] v;
    logic [NCH-1:0] b;
    logic [NCH-1:0] exp_ready;
    logic           exp_mv;
    int             exp_ch;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_vec(input logic en, input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                                  input logic [NCH-1:0] rdy, input logic mv, input int ch);
    vec_t t;
    t.en = en; t.v = v; t.b = b; t.exp_ready = rdy; t.exp_mv = mv; t.exp_ch = ch;
    tbl.push_back(t);
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_rr = 0; m_pat = int'(PAT_RESET);
    m_mv = 0; m_ch = 0; m_err = 0;
    for (int k = 0; k < NCH; k++) begin
      m_hist[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, score combinational outputs, clock, score registered outputs
  task automatic step(input logic en, input logic we, input logic [PAT_W-1:0] pat,
                      input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic clr, input logic [CH_W-1:0] sel);
    int g;
    int win;
    bit hit;
    enable = en; cfg_we = we; cfg_pattern = pat; req_valid = v; req_bit = b;
    cnt_clr = clr; cnt_sel = sel;
    g = -1;
    if (m_mode == M_RUN && en) begin
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (m_rr + i) % NCH;
        if (g < 0 && v[k]) g = k;
      end
    end
    #2;
    smp_ready = req_ready;
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("cnt_data_comb", 32'(cnt_data), 32'(m_cnt[sel]));
    hit = 1'b0;
    if (g >= 0) begin
      win = ((m_hist[g] << 1) | int'(b[g])) & ((1 << PAT_W) - 1);
      hit = (m_n[g] >= PAT_W - 1) && (win == m_pat);
      m_hist[g] = win;
      m_n[g]++;
      m_rr = (g + 1) % NCH;
    end
    m_err = (m_mode == M_RUN && we) ? 1 : 0;
    m_mv  = hit ? 1 : 0;
    if (hit) m_ch = g;
    if (clr) begin
      for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    end else if (hit && m_cnt[g] < CNT_MAX) begin
      m_cnt[g]++;
    end
    case (m_mode)
      M_IDLE:  if (we) m_pat = int'(pat); else if (en) m_mode = M_RUN;
      M_RUN:   if (!en) m_mode = M_FLUSH;
      default: begin
        for (int k = 0; k < NCH; k++) begin m_hist[k] = 0; m_n[k] = 0; end
        m_mode = M_IDLE;
      end
    endcase
    @(posedge clk); #1;
    chk("match_valid", 32'(match_valid), 32'(m_mv));
    chk("match_ch", 32'(match_ch), 32'(m_ch));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("busy", 32'(busy), (m_mode != M_IDLE) ? 32'd1 : 32'd0);
    chk("cnt_data_reg", 32'(cnt_data), 32'(m_cnt[sel]));
  endtask

  // Serial bits on one channel, MSB first; mask bit i set if a match followed bit i+1
  task automatic feed(input int ch, input logic [31:0] bits, input int n, output logic [31:0] mask);
    logic [NCH-1:0] vv;
    logic [NCH-1:0] bv;
    mask = '0;
    for (int i = 0; i < n; i++) begin
      vv = '0; bv = '0;
      vv[ch] = 1'b1;
      bv[ch] = bits[n-1-i];
      step(1'b1, 1'b0, '0, vv, bv, 1'b0, CH_W'(ch));
      if (match_valid) mask[i] = 1'b1;
    end
  endtask

  task automatic idle_cycle(input logic en);
    step(en, 1'b0, '0, '0, '0, 1'b0, cnt_sel);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_match_valid"}, 32'(match_valid), 32'd0);
    chk({tag, "_match_ch"}, 32'(match_ch), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt_data"}, 32'(cnt_data), 32'd0);
  endtask

  initial begin
    logic [31:0] mask;

    // Power-on reset
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    model_reset();
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Table: round-robin fairness, enable drop, default pattern on ch0
    add_vec(1, 4'h0, 4'h0, 4'h0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      add_vec(1, 4'hF, 4'h0, 4'h1, 0, 0);
      add_vec(1, 4'hF, 4'h0, 4'h2, 0, 0);
      add_vec(1, 4'hF, 4'h0, 4'h4, 0, 0);
      add_vec(1, 4'hF, 4'h0, 4'h8, 0, 0);
    end
    add_vec(1, 4'hD, 4'h0, 4'h1, 0, 0);
    add_vec(1, 4'hD, 4'h0, 4'h4, 0, 0);
    add_vec(1, 4'hD, 4'h0, 4'h8, 0, 0);
    add_vec(1, 4'hD, 4'h0, 4'h1, 0, 0);
    add_vec(0, 4'hF, 4'h0, 4'h0, 0, 0);
    add_vec(0, 4'hF, 4'h0, 4'h0, 0, 0);
    add_vec(1, 4'h0, 4'h0, 4'h0, 0, 0);
    add_vec(1, 4'h1, 4'h1, 4'h1, 0, 0);
    add_vec(1, 4'h1, 4'h0, 4'h1, 0, 0);
    add_vec(1, 4'h1, 4'h1, 4'h1, 0, 0);
    add_vec(1, 4'h1, 4'h1, 4'h1, 0, 0);
    add_vec(1, 4'h1, 4'h0, 4'h1, 1, 0);
    add_vec(1, 4'h1, 4'h1, 4'h1, 0, 0);
    add_vec(1, 4'h1, 4'h1, 4'h1, 0, 0);
    add_vec(1, 4'h1, 4'h0, 4'h1, 1, 0);
    foreach (tbl[i]) begin
      step(tbl[i].en, 1'b0, '0, tbl[i].v, tbl[i].b, 1'b0, '0);
      chk($sformatf("tbl%0d_ready", i), 32'(smp_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_match", i), 32'(match_valid), 32'(tbl[i].exp_mv));
      if (tbl[i].exp_mv) chk($sformatf("tbl%0d_ch", i), 32'(match_ch), 32'(tbl[i].exp_ch));
    end
    chk("cnt0_default", 32'(cnt_data), 32'd2);

    // Reconfigure in IDLE (simultaneous enable ignored), then 1010101 on ch2
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    step(1'b1, 1'b1, 5'b10101, '0, '0, 1'b0, 2'd2);
    chk("cfg_idle_busy", 32'(busy), 32'd0);
    chk("cfg_idle_err", 32'(cfg_err), 32'd0);
    idle_cycle(1'b1);
    feed(2, 32'b1010101, 7, mask);
    chk("reconf_match_pos", mask, 32'h50);
    chk("reconf_match_ch", 32'(match_ch), 32'd2);

    // Rejected write in RUN, pattern must survive
    step(1'b1, 1'b1, 5'b00000, '0, '0, 1'b0, 2'd2);
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    idle_cycle(1'b1);
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    feed(2, 32'b01, 2, mask);
    chk("pattern_kept", mask, 32'h2);

    // Flush: one busy FLUSH cycle, then five fresh bits needed
    idle_cycle(1'b0);
    chk("flush_busy", 32'(busy), 32'd1);
    idle_cycle(1'b0);
    chk("flush_to_idle", 32'(busy), 32'd0);
    idle_cycle(1'b1);
    feed(2, 32'b010101, 6, mask);
    chk("fresh_after_flush", mask, 32'h20);

    // Saturation on ch3 with the default pattern restored
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    step(1'b1, 1'b1, 5'b10110, '0, '0, 1'b0, 2'd3);
    idle_cycle(1'b1);
    feed(3, 32'b10110110110110110, 17, mask);
    chk("sat_match_pos", mask, 32'h12490);
    chk("cnt3_saturated", 32'(cnt_data), 32'd3);

    // enable drop on the completing bit: no grant, no match
    feed(3, 32'b11, 2, mask);
    step(1'b0, 1'b0, '0, 4'b1000, 4'b0000, 1'b0, 2'd3);
    chk("drop_ready", 32'(smp_ready), 32'd0);
    chk("drop_no_match", 32'(match_valid), 32'd0);

    // Asynchronous reset after four bits of 10110 on ch0
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    feed(0, 32'b1011, 4, mask);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    enable = 1'b0; cfg_we = 1'b0; req_valid = '0; req_bit = '0; cnt_clr = 1'b0;
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    idle_cycle(1'b1);
    feed(0, 32'b0, 1, mask);
    chk("post_reset_trailing0", mask, 32'h0);

    // cnt_clr on the same cycle as a counting match
    feed(3, 32'b10110110, 8, mask);
    chk("clr_setup_pos", mask, 32'h90);
    chk("clr_setup_cnt", 32'(cnt_data), 32'd2);
    feed(3, 32'b11, 2, mask);
    step(1'b1, 1'b0, '0, 4'b1000, 4'b0000, 1'b1, 2'd3);
    chk("clr_coincide_match", 32'(match_valid), 32'd1);
    chk("clr_coincide_cnt", 32'(cnt_data), 32'd0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      logic             en;
      logic             we;
      logic             clr;
      logic [PAT_W-1:0] p;
      logic [NCH-1:0]   v;
      logic [NCH-1:0]   b;
      logic [CH_W-1:0]  s;
      en  = ($urandom_range(0, 19) != 0);
      we  = ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 49) == 0);
      p   = PAT_W'($urandom);
      v   = NCH'($urandom);
      b   = NCH'($urandom);
      s   = CH_W'($urandom);
      step(en, we, p, v, b, clr, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
